// File: rtl/arm_mc_controller_if.sv
// ============================================================================
// Module : arm_mc_controller_if
// Control/datapath bundle between the multicycle ARM controller and datapath.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface arm_mc_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        IRWrite;
  logic        AdrSrc;
  logic [1:0]  RegSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  ALUControl;
  logic        Illegal;
  logic [3:0]  State;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Illegal, State
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Illegal, State
  );
endinterface

`default_nettype wire

// File: rtl/arm_mc_controller.sv
// ============================================================================
// Module : arm_mc_controller
// Multicycle ARM control FSM with condition flags and datapath selects.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module arm_mc_controller #(
  parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
  input  wire logic            clk,
  input  wire logic            reset,
  arm_mc_controller_if.master  bus
);

  localparam logic [1:0] c_ALU_ADD = 2'b00;
  localparam logic [1:0] c_ALU_SUB = 2'b01;
  localparam logic [1:0] c_ALU_AND = 2'b10;
  localparam logic [1:0] c_ALU_ORR = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_flags;
  logic        r_cond_ex;

  logic [3:0]  w_cond;
  logic [1:0]  w_op;
  logic [5:0]  w_funct;
  logic [3:0]  w_rd;
  logic        w_cond_ex;
  logic [1:0]  w_alu_op;
  logic        w_no_write;
  logic        w_cv_upd;
  logic        w_wr;
  logic        w_unused;

  logic        w_pc_write, w_mem_write, w_reg_write, w_ir_write, w_illegal;
  logic        w_adr_src;
  logic [1:0]  w_reg_src, w_src_a, w_src_b, w_result_src, w_imm_src, w_alu_ctl;

  // Instr carries bits [31:12] of the instruction word.
  assign w_cond   = bus.Instr[19:16];
  assign w_op     = bus.Instr[15:14];
  assign w_funct  = bus.Instr[13:8];
  assign w_rd     = bus.Instr[3:0];
  assign w_unused = ^bus.Instr[7:4];

  always_comb begin
    w_cond_ex = 1'b0;
    case (w_cond)
      4'h0: w_cond_ex = r_flags[2];
      4'h1: w_cond_ex = ~r_flags[2];
      4'h2: w_cond_ex = r_flags[1];
      4'h3: w_cond_ex = ~r_flags[1];
      4'h4: w_cond_ex = r_flags[3];
      4'h5: w_cond_ex = ~r_flags[3];
      4'h6: w_cond_ex = r_flags[0];
      4'h7: w_cond_ex = ~r_flags[0];
      4'h8: w_cond_ex = r_flags[1] & ~r_flags[2];
      4'h9: w_cond_ex = ~r_flags[1] | r_flags[2];
      4'hA: w_cond_ex = (r_flags[3] == r_flags[0]);
      4'hB: w_cond_ex = (r_flags[3] != r_flags[0]);
      4'hC: w_cond_ex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
      4'hD: w_cond_ex = r_flags[2] | (r_flags[3] != r_flags[0]);
      4'hE: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  // Unrecognised commands behave as a TST-like AND that never writes back.
  always_comb begin
    w_alu_op   = c_ALU_AND;
    w_no_write = 1'b1;
    w_cv_upd   = 1'b0;
    case (w_funct[4:1])
      4'b0100: begin w_alu_op = c_ALU_ADD; w_no_write = 1'b0; w_cv_upd = 1'b1; end
      4'b0010: begin w_alu_op = c_ALU_SUB; w_no_write = 1'b0; w_cv_upd = 1'b1; end
      4'b0000: begin w_alu_op = c_ALU_AND; w_no_write = 1'b0; end
      4'b1100: begin w_alu_op = c_ALU_ORR; w_no_write = 1'b0; end
      4'b1010: begin w_alu_op = c_ALU_SUB; w_cv_upd = 1'b1; end
      default: begin w_alu_op = c_ALU_AND; end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_flags   <= FLAGS_INIT;
      r_cond_ex <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_cond_ex <= w_cond_ex;
      end
      if ((r_state == S_EXECUTER || r_state == S_EXECUTEI) && w_funct[0] && r_cond_ex) begin
        r_flags[3:2] <= bus.ALUFlags[3:2];
        if (w_cv_upd) begin
          r_flags[1:0] <= bus.ALUFlags[1:0];
        end
      end
    end
  end

  always_comb begin
    w_next       = S_FETCH;
    w_pc_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_illegal    = 1'b0;
    w_adr_src    = 1'b0;
    w_reg_src    = 2'b00;
    w_src_a      = 2'b00;
    w_src_b      = 2'b00;
    w_result_src = 2'b00;
    w_imm_src    = 2'b00;
    w_alu_ctl    = c_ALU_ADD;
    w_wr         = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_next       = S_DECODE;
        w_ir_write   = 1'b1;
        w_pc_write   = 1'b1;
        w_src_a      = 2'b01;
        w_src_b      = 2'b10;
        w_result_src = 2'b10;
      end
      S_DECODE: begin
        w_src_a   = 2'b01;
        w_src_b   = 2'b10;
        w_reg_src = {(w_op == 2'b01) && !w_funct[0], w_op == 2'b10};
        w_imm_src = w_op;
        case (w_op)
          2'b00:   w_next = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: begin w_next = S_FETCH; w_illegal = 1'b1; end
        endcase
      end
      S_MEMADR: begin
        w_next    = w_funct[0] ? S_MEMRD : S_MEMWR;
        w_src_b   = 2'b01;
        w_imm_src = 2'b01;
      end
      S_MEMRD: begin
        w_next    = S_MEMWB;
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_wr         = r_cond_ex;
      end
      S_MEMWR: begin
        w_adr_src   = 1'b1;
        w_reg_src   = 2'b10;
        w_mem_write = r_cond_ex;
      end
      S_EXECUTER: begin
        w_next    = S_ALUWB;
        w_alu_ctl = w_alu_op;
      end
      S_EXECUTEI: begin
        w_next    = S_ALUWB;
        w_src_b   = 2'b01;
        w_alu_ctl = w_alu_op;
      end
      S_ALUWB: begin
        w_wr = r_cond_ex & ~w_no_write;
      end
      S_BRANCH: begin
        w_src_a      = 2'b10;
        w_src_b      = 2'b01;
        w_imm_src    = 2'b10;
        w_result_src = 2'b10;
        w_pc_write   = r_cond_ex;
      end
      default: w_next = S_FETCH;
    endcase
    // A write-back to R15 is steered to the PC instead of the register file.
    if (w_wr) begin
      if (w_rd == 4'hF) w_pc_write  = 1'b1;
      else              w_reg_write = 1'b1;
    end
  end

  assign bus.PCWrite    = w_pc_write  & reset;
  assign bus.MemWrite   = w_mem_write & reset;
  assign bus.RegWrite   = w_reg_write & reset;
  assign bus.IRWrite    = w_ir_write  & reset;
  assign bus.Illegal    = w_illegal   & reset;
  assign bus.AdrSrc     = w_adr_src;
  assign bus.RegSrc     = w_reg_src;
  assign bus.ALUSrcA    = w_src_a;
  assign bus.ALUSrcB    = w_src_b;
  assign bus.ResultSrc  = w_result_src;
  assign bus.ImmSrc     = w_imm_src;
  assign bus.ALUControl = w_alu_ctl;
  assign bus.State      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_arm_mc_controller.sv
// ============================================================================
// Module : tb_arm_mc_controller
// Randomised scoreboard bench for arm_mc_controller against an instruction-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_arm_mc_controller;

  logic clk;
  logic reset;
  arm_mc_controller_if bus();

  arm_mc_controller #(.FLAGS_INIT(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [21:0] q_exp[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [3:0]  m_flags;

  // {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
  //  ALUSrcB, ResultSrc, ImmSrc, ALUControl, Illegal}
  function automatic logic [21:0] observed();
    return {bus.State, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite,
            bus.AdrSrc, bus.RegSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
            bus.ImmSrc, bus.ALUControl, bus.Illegal};
  endfunction

  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Data-processing command: ALU operation, whether Rd is written, whether C/V follow the ALU.
  function automatic void alu_info(input logic [3:0] cmd, output logic [1:0] ctl,
                                   output bit writes, output bit cv);
    ctl = 2'd2; writes = 0; cv = 0;
    if (cmd == 4'd4)       begin ctl = 2'd0; writes = 1; cv = 1; end
    else if (cmd == 4'd2)  begin ctl = 2'd1; writes = 1; cv = 1; end
    else if (cmd == 4'd0)  begin ctl = 2'd2; writes = 1; end
    else if (cmd == 4'd12) begin ctl = 2'd3; writes = 1; end
    else if (cmd == 4'd10) begin ctl = 2'd1; cv = 1; end
  endfunction

  function automatic void state_seq(input logic [31:0] ins, output int seq[$]);
    seq = {0, 1};
    case (ins[27:26])
      2'b00: begin seq.push_back(ins[25] ? 7 : 6); seq.push_back(8); end
      2'b01: begin seq.push_back(2); if (ins[20]) begin seq.push_back(3); seq.push_back(4); end
                   else seq.push_back(5); end
      2'b10: seq.push_back(9);
      default: ;
    endcase
  endfunction

  function automatic logic [21:0] expv(input int st, input logic [31:0] ins,
                                       input bit cx, input bit rst_low);
    logic pcw, mw, rw, irw, adr, ill;
    logic [1:0] rs, sa, sb, res, imm, ac, op, dp_ctl;
    bit wr, cv, commit;
    pcw = 0; mw = 0; rw = 0; irw = 0; adr = 0; ill = 0;
    rs = 0; sa = 0; sb = 0; res = 0; imm = 0; ac = 0;
    op = ins[27:26];
    alu_info(ins[24:21], dp_ctl, wr, cv);
    commit = 0;
    case (st)
      0: begin irw = 1; pcw = 1; sa = 2'd1; sb = 2'd2; res = 2'd2; end
      1: begin sa = 2'd1; sb = 2'd2; rs = {op == 2'd1 && !ins[20], op == 2'd2};
               imm = op; ill = (op == 2'd3); end
      2: begin sb = 2'd1; imm = 2'd1; end
      3: adr = 1;
      4: begin res = 2'd1; commit = cx; end
      5: begin adr = 1; rs = 2'd2; mw = cx; end
      6: ac = dp_ctl;
      7: begin ac = dp_ctl; sb = 2'd1; end
      8: commit = cx && wr;
      9: begin sa = 2'd2; sb = 2'd1; imm = 2'd2; res = 2'd2; pcw = cx; end
      default: ;
    endcase
    if (commit) begin
      if (ins[15:12] == 4'hF) pcw = 1;
      else rw = 1;
    end
    if (rst_low) begin pcw = 0; mw = 0; rw = 0; irw = 0; ill = 0; end
    return {4'(st), pcw, mw, rw, irw, adr, rs, sa, sb, res, imm, ac, ill};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plays one instruction cycle by cycle; stop_after > 0 truncates it (for mid-instruction reset).
  task automatic run_instr(input logic [31:0] ins, input bit fix, input logic [3:0] xf,
                           input int stop_after);
    int seq[$];
    bit cx, wr, cv;
    logic [1:0] ctl;
    logic [3:0] af;
    int n;
    state_seq(ins, seq);
    cx = cond_pass(ins[31:28], m_flags);
    alu_info(ins[24:21], ctl, wr, cv);
    n = (stop_after > 0) ? stop_after : seq.size();
    for (int i = 0; i < n; i++) begin
      step();
      reset = 1'b1;
      bus.Instr = ins[31:12];
      af = 4'($urandom);
      if (fix && (seq[i] == 6 || seq[i] == 7)) af = xf;
      bus.ALUFlags = af;
      q_exp.push_back(expv(seq[i], ins, cx, 1'b0));
      if ((seq[i] == 6 || seq[i] == 7) && ins[20] && cx) begin
        m_flags[3:2] = af[3:2];
        if (cv) m_flags[1:0] = af[1:0];
      end
    end
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      bus.ALUFlags = 4'($urandom);
      q_exp.push_back(expv(0, 32'h0, 1'b0, 1'b1));
    end
  endtask

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      logic [21:0] e, o;
      e = q_exp.pop_front();
      o = observed();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL ctrl_vec t=%0t state got %0d exp %0d : vec got %h exp %h",
                 $time, o[21:18], e[21:18], o, e);
      end
    end
  end

  initial begin
    logic [31:0] ins;
    reset = 1'b0;
    bus.Instr = 20'h0;
    bus.ALUFlags = 4'h0;
    m_flags = 4'b0000;
    reset_cycles(3);

    run_instr(32'hE2801005, 0, 4'h0, 0);   // ADD R1,R0,#5
    run_instr(32'hE2512005, 1, 4'b0100, 0); // SUBS -> Z
    run_instr(32'h0A000001, 0, 4'h0, 0);   // BEQ taken
    run_instr(32'hE3510005, 1, 4'b1000, 0); // CMP -> N
    run_instr(32'h0A000001, 0, 4'h0, 0);   // BEQ not taken
    run_instr(32'hE5903008, 0, 4'h0, 0);   // LDR
    run_instr(32'hE5803008, 0, 4'h0, 0);   // STR
    run_instr(32'hEC000000, 0, 4'h0, 0);   // Op=11
    run_instr(32'hE281F004, 0, 4'h0, 0);   // ADD R15,R1,#4

    // Set Z, then abandon a register ADD in EXECUTER via reset; flags must clear.
    run_instr(32'hE2512005, 1, 4'b0100, 0);
    run_instr(32'hE0812000, 0, 4'h0, 3);
    @(negedge clk);
    #1;
    reset = 1'b0;
    m_flags = 4'b0000;
    reset_cycles(3);
    run_instr(32'h0A000001, 0, 4'h0, 0);

    for (int k = 0; k < 200; k++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) ins[31:28] = 4'hE;
      if ($urandom_range(0, 5) == 0) ins[15:12] = 4'hF;
      run_instr(ins, 0, 4'h0, 0);
    end

    step();
    @(negedge clk);
    #1;
    n_cmp++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending got %0d required 0", q_exp.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
